// File: rtl/un_striping_n.sv
// ---------------------------------------------------------------------------
// un_striping_n
//   Lane un-striper for the PHY receive path. LANES lanes of WIDTH bits each
//   feed a per-lane deskew FIFO of DEPTH entries; the FIFOs are drained
//   round-robin, one word per cycle, into a single word stream.
//
//   ALIGN = 1 : the selector waits on an empty lane, so the output order is
//               strictly lane 0,1,..,LANES-1,0,.. regardless of lane skew.
//   ALIGN = 0 : the selector advances every cycle (legacy toggle behaviour).
//
// Ports
//   clk_2f     : only clock, rising edge
//   reset      : synchronous, active-high
//   lane_data  : lane i word in bits [i*WIDTH +: WIDTH]
//   lane_valid : bit i qualifies lane i's word this cycle
//   clear_err  : clears the sticky overflow flags on the next edge
//   data_out   : un-striped word, zero when valid_out = 0
//   valid_out  : data_out holds a word
//   sel_out    : lane that sourced the current data_out
//   overflow   : sticky per-lane drop flags
// ---------------------------------------------------------------------------
module un_striping_n #(
  parameter  int WIDTH = 32,
  parameter  int LANES = 2,
  parameter  int DEPTH = 4,
  parameter  int ALIGN = 1,
  localparam int SW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]       lane_valid,
  input  logic                   clear_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [SW-1:0]          sel_out,
  output logic [LANES-1:0]       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem   [LANES][DEPTH];
  logic [PW-1:0]    wptr  [LANES];
  logic [PW-1:0]    rptr  [LANES];
  logic [CW-1:0]    count [LANES];
  logic [SW-1:0]    sel;

  logic [LANES-1:0] pop;
  logic [LANES-1:0] push_ok;
  logic [LANES-1:0] drop;
  logic             head_avail;
  logic [WIDTH-1:0] head_word;

  // A full FIFO still accepts a push when the same lane is popped on this
  // edge; the pop frees the slot the push fills.
  always_comb begin
    pop        = '0;
    push_ok    = '0;
    drop       = '0;
    head_avail = (count[sel] != '0);
    head_word  = mem[sel][rptr[sel]];
    for (int unsigned i = 0; i < LANES; i++) begin
      pop[i]     = head_avail && (sel == SW'(i));
      push_ok[i] = lane_valid[i] && ((count[i] < CW'(DEPTH)) || pop[i]);
      drop[i]    = lane_valid[i] && !push_ok[i];
    end
  end

  // Storage is not reset; counts and pointers alone define what is valid.
  always_ff @(posedge clk_2f) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (push_ok[i]) begin
        mem[i][wptr[i]] <= lane_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        count[i] <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
      end
      sel       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sel_out   <= '0;
      overflow  <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (push_ok[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])     rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push_ok[i]) - CW'(pop[i]);
        // A drop on the same edge as clear_err leaves the flag set.
        overflow[i] <= drop[i] | (overflow[i] & ~clear_err);
      end

      if (head_avail) begin
        data_out  <= head_word;
        valid_out <= 1'b1;
        sel_out   <= sel;
        sel       <= sel + SW'(1);
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
        if (ALIGN == 0) sel <= sel + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_un_striping_n.sv
// ---------------------------------------------------------------------------
// tb_un_striping_n
//   Directed bench for un_striping_n. Three instances cover the legacy
//   two-lane toggle mode, four-lane skew alignment, and the two-lane aligned
//   FIFO corner cases (overflow, full with pop, clear vs. drop, reset).
//   Expected output words are queued per instance and compared in order as
//   valid_out words appear.
// ---------------------------------------------------------------------------
module tb_un_striping_n;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_2f = ~clk_2f;

  // Instance A: legacy, LANES=2, ALIGN=0
  logic [63:0]  a_data  = '0;
  logic [1:0]   a_valid = '0;
  logic         a_clr   = 1'b0;
  logic [31:0]  a_dout;
  logic         a_vout;
  logic         a_sel;
  logic [1:0]   a_ovf;

  // Instance B: LANES=4, ALIGN=1
  logic [127:0] b_data  = '0;
  logic [3:0]   b_valid = '0;
  logic         b_clr   = 1'b0;
  logic [31:0]  b_dout;
  logic         b_vout;
  logic [1:0]   b_sel;
  logic [3:0]   b_ovf;

  // Instance C: LANES=2, ALIGN=1
  logic [63:0]  c_data  = '0;
  logic [1:0]   c_valid = '0;
  logic         c_clr   = 1'b0;
  logic [31:0]  c_dout;
  logic         c_vout;
  logic         c_sel;
  logic [1:0]   c_ovf;

  un_striping_n #(.WIDTH(32), .LANES(2), .DEPTH(4), .ALIGN(0)) u_a (
    .clk_2f(clk_2f), .reset(reset), .lane_data(a_data), .lane_valid(a_valid),
    .clear_err(a_clr), .data_out(a_dout), .valid_out(a_vout), .sel_out(a_sel),
    .overflow(a_ovf));

  un_striping_n #(.WIDTH(32), .LANES(4), .DEPTH(4), .ALIGN(1)) u_b (
    .clk_2f(clk_2f), .reset(reset), .lane_data(b_data), .lane_valid(b_valid),
    .clear_err(b_clr), .data_out(b_dout), .valid_out(b_vout), .sel_out(b_sel),
    .overflow(b_ovf));

  un_striping_n #(.WIDTH(32), .LANES(2), .DEPTH(4), .ALIGN(1)) u_c (
    .clk_2f(clk_2f), .reset(reset), .lane_data(c_data), .lane_valid(c_valid),
    .clear_err(c_clr), .data_out(c_dout), .valid_out(c_vout), .sel_out(c_sel),
    .overflow(c_ovf));

  // Scoreboard entries are {8-bit lane, 32-bit word}.
  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [39:0] qc[$];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic sb_a();
    logic [39:0] e;
    if (a_vout) begin
      if (qa.size() == 0) check("a_extra_word", a_vout, 1'b0);
      else begin
        e = qa.pop_front();
        check("a_word", {7'd0, a_sel, a_dout}, e);
      end
    end else check("a_idle_zero", a_dout, 32'd0);
  endtask

  task automatic sb_b();
    logic [39:0] e;
    if (b_vout) begin
      if (qb.size() == 0) check("b_extra_word", b_vout, 1'b0);
      else begin
        e = qb.pop_front();
        check("b_word", {6'd0, b_sel, b_dout}, e);
      end
    end else check("b_idle_zero", b_dout, 32'd0);
  endtask

  task automatic sb_c();
    logic [39:0] e;
    if (c_vout) begin
      if (qc.size() == 0) check("c_extra_word", c_vout, 1'b0);
      else begin
        e = qc.pop_front();
        check("c_word", {7'd0, c_sel, c_dout}, e);
      end
    end else check("c_idle_zero", c_dout, 32'd0);
  endtask

  task automatic cstep(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic clr);
    c_valid = v;
    c_data  = {d1, d0};
    c_clr   = clr;
    tick();
    sb_c();
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_a_vout", a_vout, 1'b0);
    check("rst_a_dout", a_dout, 32'd0);
    check("rst_b_vout", b_vout, 1'b0);
    check("rst_b_sel",  b_sel,  2'd0);
    check("rst_b_ovf",  b_ovf,  4'd0);
    check("rst_c_vout", c_vout, 1'b0);
    check("rst_c_ovf",  c_ovf,  2'd0);
    reset = 1'b0;

    // ---------------- legacy toggle, ALIGN=0 ----------------
    for (int n = 0; n < 10; n++) begin
      a_valid = (n % 2 == 0) ? 2'b01 : 2'b10;
      a_data  = (n % 2 == 0) ? {32'h0, 32'hA0A0A0A0} : {32'hB1B1B1B1, 32'h0};
      qa.push_back({8'(n % 2), (n % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1});
      tick();
      sb_a();
      if (n < 2) check("a_latency_gap", a_vout, 1'b0);
      else       check("a_continuous", a_vout, 1'b1);
    end
    a_valid = '0;
    a_data  = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      sb_a();
    end
    check("a_drained", qa.size(), 0);
    check("a_ovf", a_ovf, 2'd0);

    // ---------------- skew alignment, LANES=4, ALIGN=1 ----------------
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < 4; i++)
        qb.push_back({8'(i), 32'(i * 16 + n)});
    for (int t = 0; t < 45; t++) begin
      b_valid = '0;
      b_data  = '0;
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (i == 2) ? 3 : 0;
        if (t >= d && (t - d) % 4 == 0 && (t - d) / 4 < 8) begin
          b_valid[i] = 1'b1;
          b_data[i*32 +: 32] = 32'(i * 16 + (t - d) / 4);
        end
      end
      tick();
      sb_b();
    end
    check("b_drained", qb.size(), 0);
    check("b_ovf", b_ovf, 4'd0);

    // ---------------- overflow on lane 1, lane 0 silent ----------------
    for (int k = 0; k < 6; k++) begin
      cstep(2'b10, 32'h0, 32'h1000 + 32'(k), 1'b0);
      if (k == 3) check("c_ovf_at_full", c_ovf, 2'b00);
    end
    check("c_ovf_dropped", c_ovf, 2'b10);
    for (int k = 0; k < 4; k++) begin
      qc.push_back({8'd0, 32'h2000 + 32'(k)});
      qc.push_back({8'd1, 32'h1000 + 32'(k)});
    end
    for (int k = 0; k < 4; k++) cstep(2'b01, 32'h2000 + 32'(k), 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) cstep(2'b00, 32'h0, 32'h0, 1'b0);
    check("c_ovf_drained", qc.size(), 0);
    cstep(2'b00, 32'h0, 32'h0, 1'b1);
    check("c_ovf_cleared", c_ovf, 2'b00);

    // ---------------- full lane 0 with push and pop on one edge ----------------
    qc.push_back({8'd0, 32'h3000});
    qc.push_back({8'd1, 32'h4000});
    for (int k = 0; k < 5; k++) begin
      qc.push_back({8'd0, 32'h3100 + 32'(k)});
      qc.push_back({8'd1, 32'h4001 + 32'(k)});
    end
    cstep(2'b01, 32'h3000, 32'h0, 1'b0);
    cstep(2'b01, 32'h3100, 32'h0, 1'b0);
    cstep(2'b01, 32'h3101, 32'h0, 1'b0);
    cstep(2'b01, 32'h3102, 32'h0, 1'b0);
    cstep(2'b11, 32'h3103, 32'h4000, 1'b0);
    cstep(2'b00, 32'h0, 32'h0, 1'b0);
    cstep(2'b01, 32'h3104, 32'h0, 1'b0);
    check("c_full_pop_ovf", c_ovf, 2'b00);
    check("c_full_pop_out", {c_vout, c_dout}, {1'b1, 32'h3100});
    for (int k = 0; k < 5; k++) cstep(2'b10, 32'h0, 32'h4001 + 32'(k), 1'b0);
    for (int k = 0; k < 8; k++) cstep(2'b00, 32'h0, 32'h0, 1'b0);
    check("c_full_pop_drained", qc.size(), 0);
    check("c_full_pop_ovf_end", c_ovf, 2'b00);

    // ---------------- clear vs. drop ----------------
    for (int k = 0; k < 4; k++) cstep(2'b10, 32'h0, 32'h5000 + 32'(k), 1'b0);
    cstep(2'b10, 32'h0, 32'h5004, 1'b1);
    check("c_clr_vs_drop", c_ovf, 2'b10);
    cstep(2'b00, 32'h0, 32'h0, 1'b1);
    check("c_clr_alone", c_ovf, 2'b00);
    cstep(2'b10, 32'h0, 32'h5005, 1'b0);
    check("c_drop_again", c_ovf, 2'b10);

    // ---------------- reset mid-stream with 3 words buffered ----------------
    qc.push_back({8'd0, 32'h6000});
    qc.push_back({8'd1, 32'h5000});
    cstep(2'b01, 32'h6000, 32'h0, 1'b0);
    cstep(2'b00, 32'h0, 32'h0, 1'b0);
    cstep(2'b00, 32'h0, 32'h0, 1'b0);
    check("c_pre_rst_q", qc.size(), 0);
    check("c_pre_rst_sel", c_sel, 1'b1);
    reset   = 1'b1;
    c_valid = 2'b01;
    c_data  = {32'h0, 32'hDEADBEEF};
    tick();
    check("c_rst_vout", c_vout, 1'b0);
    check("c_rst_dout", c_dout, 32'd0);
    check("c_rst_sel",  c_sel,  1'b0);
    check("c_rst_ovf",  c_ovf,  2'b00);
    reset = 1'b0;
    qc.push_back({8'd0, 32'h7000});
    cstep(2'b01, 32'h7000, 32'h0, 1'b0);
    check("c_post_rst_lat1", c_vout, 1'b0);
    cstep(2'b00, 32'h0, 32'h0, 1'b0);
    check("c_post_rst_lat2", c_vout, 1'b1);
    for (int k = 0; k < 5; k++) cstep(2'b00, 32'h0, 32'h0, 1'b0);
    check("c_post_rst_drained", qc.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
